// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - RV32 subset instruction decode stage with single-entry ID/EX register
// Decodes {inst, pc} from fetch into EX controls and holds them behind a valid/ready handshake.
module id_decode_stage #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_valid_i,
  output logic                 inst_ready_o,
  input  logic [XLEN-1:0]      inst_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic                 flush_i,
  input  logic                 ex_ready_i,
  output logic                 ex_valid_o,
  output logic [4:0]           ALUop_o,
  output logic                 ALUSrc1_o,
  output logic                 ALUSrc2_o,
  output logic [XLEN-1:0]      Imm_o,
  output logic [XLEN-1:0]      PC_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [4:0]           rd_o,
  output logic                 RegWrite_o,
  output logic                 MemRead_o,
  output logic                 MemWrite_o,
  output logic                 Branch_o,
  output logic                 Jump_o,
  output logic                 illegal_o,
  output logic [ILL_CNT_W-1:0] ill_count_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic [4:0]      d_aluop;
  logic            d_src1, d_src2;
  logic [XLEN-1:0] d_imm;
  logic            d_regw, d_memr, d_memw, d_br, d_jmp, d_ill;
  logic            accept;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rd     = inst_i[11:7];

  assign imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

  // Flush blocks capture, so the stage must not advertise ready while flushing.
  assign inst_ready_o = !flush_i && (!ex_valid_o || ex_ready_i);
  assign accept       = inst_valid_i && inst_ready_o;

  always_comb begin
    d_aluop = 5'b00000;
    d_src1  = 1'b0;
    d_src2  = 1'b0;
    d_imm   = '0;
    d_regw  = 1'b0;
    d_memr  = 1'b0;
    d_memw  = 1'b0;
    d_br    = 1'b0;
    d_jmp   = 1'b0;
    d_ill   = 1'b0;
    case (opcode)
      7'b0110011: begin
        d_regw = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: d_aluop = 5'b01101;
          10'b0100000_000: d_aluop = 5'b01110;
          10'b0000000_001: d_aluop = 5'b01000;
          10'b0000000_100: d_aluop = 5'b00110;
          10'b0000000_101: d_aluop = 5'b01001;
          10'b0000000_110: d_aluop = 5'b00101;
          10'b0000000_111: d_aluop = 5'b00100;
          default:         d_ill   = 1'b1;
        endcase
      end
      7'b0010011: begin
        d_aluop = 5'b01100; d_src2 = 1'b1; d_imm = imm_i; d_regw = 1'b1;
        d_ill   = (funct3 != 3'b000);
      end
      7'b0000011: begin
        d_aluop = 5'b10100; d_src2 = 1'b1; d_imm = imm_i; d_memr = 1'b1; d_regw = 1'b1;
        d_ill   = (funct3 != 3'b010);
      end
      7'b1100111: begin
        d_aluop = 5'b10100; d_src2 = 1'b1; d_imm = imm_i; d_jmp = 1'b1; d_regw = 1'b1;
        d_ill   = (funct3 != 3'b000);
      end
      7'b0100011: begin
        d_aluop = 5'b10101; d_src2 = 1'b1; d_imm = imm_s; d_memw = 1'b1;
        d_ill   = (funct3 != 3'b010);
      end
      7'b1100011: begin
        d_aluop = 5'b10001; d_src1 = 1'b1; d_src2 = 1'b1; d_imm = imm_b; d_br = 1'b1;
        d_ill   = (funct3 != 3'b000);
      end
      default: d_ill = 1'b1;
    endcase
    // Illegal encodings become a bubble for EX: no ALU work, no side effects.
    if (d_ill) begin
      d_aluop = 5'b00000;
      d_src1  = 1'b0;
      d_src2  = 1'b0;
      d_imm   = '0;
      d_regw  = 1'b0;
      d_memr  = 1'b0;
      d_memw  = 1'b0;
      d_br    = 1'b0;
      d_jmp   = 1'b0;
    end
    if (rd == 5'd0) d_regw = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_o  <= 1'b0;
      ALUop_o     <= 5'b00000;
      ALUSrc1_o   <= 1'b0;
      ALUSrc2_o   <= 1'b0;
      Imm_o       <= '0;
      PC_o        <= '0;
      rs1_o       <= 5'd0;
      rs2_o       <= 5'd0;
      rd_o        <= 5'd0;
      RegWrite_o  <= 1'b0;
      MemRead_o   <= 1'b0;
      MemWrite_o  <= 1'b0;
      Branch_o    <= 1'b0;
      Jump_o      <= 1'b0;
      illegal_o   <= 1'b0;
      ill_count_o <= '0;
    end else begin
      illegal_o <= 1'b0;
      if (flush_i) begin
        ex_valid_o <= 1'b0;
      end else if (accept) begin
        ex_valid_o <= 1'b1;
        ALUop_o    <= d_aluop;
        ALUSrc1_o  <= d_src1;
        ALUSrc2_o  <= d_src2;
        Imm_o      <= d_imm;
        PC_o       <= pc_i;
        rs1_o      <= inst_i[19:15];
        rs2_o      <= inst_i[24:20];
        rd_o       <= rd;
        RegWrite_o <= d_regw;
        MemRead_o  <= d_memr;
        MemWrite_o <= d_memw;
        Branch_o   <= d_br;
        Jump_o     <= d_jmp;
        illegal_o  <= d_ill;
        if (d_ill && (ill_count_o != {ILL_CNT_W{1'b1}}))
          ill_count_o <= ill_count_o + 1'b1;
      end else if (ex_ready_i) begin
        ex_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - self-checking bench for id_decode_stage
// Reference model is a mask/match instruction table plus a one-slot scoreboard.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_valid_i = 1'b0;
  logic        inst_ready_o;
  logic [31:0] inst_i = '0;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        ex_ready_i = 1'b0;
  logic        ex_valid_o;
  logic [4:0]  ALUop_o;
  logic        ALUSrc1_o, ALUSrc2_o;
  logic [31:0] Imm_o, PC_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o;
  logic        illegal_o;
  logic [7:0]  ill_count_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_decode_stage #(.XLEN(32), .ILL_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_i(inst_i), .pc_i(pc_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .ex_valid_o(ex_valid_o), .ALUop_o(ALUop_o), .ALUSrc1_o(ALUSrc1_o), .ALUSrc2_o(ALUSrc2_o),
    .Imm_o(Imm_o), .PC_o(PC_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .Branch_o(Branch_o), .Jump_o(Jump_o), .illegal_o(illegal_o), .ill_count_o(ill_count_o)
  );

  // Instruction table: mask/match, ALUop, {Src1,Src2}, imm kind (0 none,1 I,2 S,3 B), {RegWrite,MemRead,MemWrite,Branch,Jump}
  logic [31:0] tbl_mask [12] = '{32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
                                 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'h0000707F,
                                 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F};
  logic [31:0] tbl_match[12] = '{32'h00000033, 32'h40000033, 32'h00001033, 32'h00004033,
                                 32'h00005033, 32'h00006033, 32'h00007033, 32'h00000013,
                                 32'h00002003, 32'h00000067, 32'h00002023, 32'h00000063};
  logic [4:0]  tbl_op   [12] = '{5'b01101, 5'b01110, 5'b01000, 5'b00110, 5'b01001, 5'b00101,
                                 5'b00100, 5'b01100, 5'b10100, 5'b10100, 5'b10101, 5'b10001};
  logic [1:0]  tbl_src  [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
  int          tbl_imm  [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 3};
  logic [4:0]  tbl_ctl  [12] = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000,
                                 5'b10000, 5'b10000, 5'b11000, 5'b10001, 5'b00100, 5'b00010};

  // Scoreboard for the single ID/EX slot
  logic        exp_valid = 1'b0;
  logic [90:0] exp_fields = '0;
  logic        exp_ill = 1'b0;
  int          exp_cnt = 0;
  logic        exp_ready;
  logic        seen_ready;

  function automatic logic [91:0] ref_decode(input logic [31:0] i, input logic [31:0] pc);
    logic [31:0] imm, sx;
    logic [4:0]  op, ctl;
    logic [1:0]  src;
    logic        ill;
    ill = 1'b1; op = '0; src = '0; ctl = '0; imm = '0;
    sx = $signed(i) >>> 20;
    for (int k = 0; k < 12; k++) begin
      if ((i & tbl_mask[k]) == tbl_match[k]) begin
        ill = 1'b0; op = tbl_op[k]; src = tbl_src[k]; ctl = tbl_ctl[k];
        case (tbl_imm[k])
          1:       imm = sx;
          2:       imm = {sx[31:5], i[11:7]};
          3:       imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
          default: imm = '0;
        endcase
      end
    end
    if (i[11:7] == 5'd0) ctl[4] = 1'b0;
    return {ill, op, src, imm, pc, i[19:15], i[24:20], i[11:7], ctl};
  endfunction

  function automatic logic [91:0] observed_bus();
    return {ex_valid_o, ALUop_o, ALUSrc1_o, ALUSrc2_o, Imm_o, PC_o, rs1_o, rs2_o, rd_o,
            RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o};
  endfunction

  // Drives one cycle of inputs, records inst_ready_o, crosses the edge and advances the model.
  task automatic drive_cycle(input logic v, input logic [31:0] i, input logic [31:0] pc,
                             input logic fl, input logic er);
    logic [91:0] r;
    inst_valid_i = v; inst_i = i; pc_i = pc; flush_i = fl; ex_ready_i = er;
    exp_ready = !fl && (!exp_valid || er);
    #1;
    seen_ready = inst_ready_o;
    @(posedge clk);
    exp_ill = 1'b0;
    if (fl) begin
      exp_valid = 1'b0;
    end else if (v && exp_ready) begin
      r = ref_decode(i, pc);
      exp_valid = 1'b1;
      exp_fields = r[90:0];
      exp_ill = r[91];
      if (r[91] && exp_cnt < 255) exp_cnt++;
    end else if (er) begin
      exp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (observed_bus() !== 92'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", observed_bus());
    end
    n_cmp++;
    if ({illegal_o, ill_count_o} !== 9'd0) begin
      n_fail++; $display("FAIL reset_ill got %b/%0d want 0/0", illegal_o, ill_count_o);
    end
    rst = 1'b1;
    exp_valid = 1'b0; exp_fields = '0; exp_ill = 1'b0; exp_cnt = 0;
  endtask

  task automatic test_addi();
    drive_cycle(1'b1, 32'hFFF00093, 32'h0000_0040, 1'b0, 1'b1);
    n_cmp++;
    if (observed_bus() !== {exp_valid, exp_fields}) begin
      n_fail++; $display("FAIL addi_bus got %h want %h", observed_bus(), {exp_valid, exp_fields});
    end
    n_cmp++;
    if ({ex_valid_o, ALUop_o, ALUSrc2_o, Imm_o, rd_o, RegWrite_o} !== {1'b1, 5'b01100, 1'b1, 32'hFFFFFFFF, 5'd1, 1'b1}) begin
      n_fail++; $display("FAIL addi_fields got op=%b imm=%h rd=%0d rw=%b", ALUop_o, Imm_o, rd_o, RegWrite_o);
    end
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    n_cmp++;
    if (ex_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL addi_drain got %b want 0", ex_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    drive_cycle(1'b1, 32'h002081B3, 32'h0000_0100, 1'b0, 1'b1);
    n_cmp++;
    if ({ex_valid_o, ALUop_o} !== {1'b1, 5'b01101}) begin
      n_fail++; $display("FAIL b2b_add got v=%b op=%b want 1/01101", ex_valid_o, ALUop_o);
    end
    drive_cycle(1'b1, 32'h402081B3, 32'h0000_0104, 1'b0, 1'b1);
    n_cmp++;
    if (seen_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready got %b want 1", seen_ready);
    end
    n_cmp++;
    if ({ex_valid_o, ALUop_o, PC_o} !== {1'b1, 5'b01110, 32'h104}) begin
      n_fail++; $display("FAIL b2b_sub got v=%b op=%b pc=%h", ex_valid_o, ALUop_o, PC_o);
    end
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    logic [91:0] first;
    drive_cycle(1'b1, 32'h0020A423, 32'h0000_0200, 1'b0, 1'b0);
    first = observed_bus();
    n_cmp++;
    if ({ALUop_o, Imm_o, MemWrite_o, RegWrite_o} !== {5'b10101, 32'd8, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sw_fields got op=%b imm=%h mw=%b rw=%b", ALUop_o, Imm_o, MemWrite_o, RegWrite_o);
    end
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      n_cmp++;
      if (seen_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_ready c%0d got %b want 0", c, seen_ready);
      end
      n_cmp++;
      if (observed_bus() !== first || first !== {exp_valid, exp_fields}) begin
        n_fail++; $display("FAIL stall_hold c%0d got %h want %h", c, observed_bus(), {exp_valid, exp_fields});
      end
    end
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    n_cmp++;
    if (ex_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_release got %b want 0", ex_valid_o);
    end
  endtask

  task automatic test_beq();
    drive_cycle(1'b1, 32'hFE208EE3, 32'h0000_0100, 1'b0, 1'b1);
    n_cmp++;
    if ({ALUop_o, ALUSrc1_o, ALUSrc2_o, Imm_o, PC_o, Branch_o, RegWrite_o} !==
        {5'b10001, 1'b1, 1'b1, 32'hFFFFFFFC, 32'h100, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL beq_fields got op=%b s=%b%b imm=%h pc=%h br=%b", ALUop_o, ALUSrc1_o, ALUSrc2_o, Imm_o, PC_o, Branch_o);
    end
    n_cmp++;
    if (observed_bus() !== {exp_valid, exp_fields}) begin
      n_fail++; $display("FAIL beq_bus got %h want %h", observed_bus(), {exp_valid, exp_fields});
    end
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 32'h00500113, 32'h0000_0300, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h002081B3, 32'h0000_0304, 1'b1, 1'b1);
    n_cmp++;
    if (seen_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready got %b want 0", seen_ready);
    end
    n_cmp++;
    if (ex_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid got %b want 0", ex_valid_o);
    end
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    n_cmp++;
    if ({ex_valid_o, illegal_o} !== 2'b00) begin
      n_fail++; $display("FAIL flush_nocapture got v=%b ill=%b want 00", ex_valid_o, illegal_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int k;
    for (int c = 0; c < 300; c++) begin
      k = $urandom_range(0, 15);
      if (k < 12) ins = tbl_match[k] | ($urandom & ~tbl_mask[k]);
      else        ins = $urandom;
      drive_cycle($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) != 0);
      n_cmp++;
      if (seen_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready c%0d got %b want %b", c, seen_ready, exp_ready);
      end
      n_cmp++;
      if (observed_bus() !== {exp_valid, exp_fields}) begin
        n_fail++; $display("FAIL rand_bus c%0d got %h want %h", c, observed_bus(), {exp_valid, exp_fields});
      end
      n_cmp++;
      if ({illegal_o, ill_count_o} !== {exp_ill, exp_cnt[7:0]}) begin
        n_fail++; $display("FAIL rand_ill c%0d got %b/%0d want %b/%0d", c, illegal_o, ill_count_o, exp_ill, exp_cnt);
      end
    end
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_saturate();
    test_reset();
    for (int c = 0; c < 257; c++) begin
      drive_cycle(1'b1, 32'hFFFFFFFF, 32'h1000 + 4 * c, 1'b0, 1'b1);
      n_cmp++;
      if ({ex_valid_o, illegal_o, ALUop_o, RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o, Imm_o} !==
          {1'b1, 1'b1, 5'b0, 5'b0, 32'd0}) begin
        n_fail++; $display("FAIL sat_bubble c%0d got v=%b ill=%b op=%b", c, ex_valid_o, illegal_o, ALUop_o);
      end
      n_cmp++;
      if (ill_count_o !== exp_cnt[7:0]) begin
        n_fail++; $display("FAIL sat_count c%0d got %0d want %0d", c, ill_count_o, exp_cnt);
      end
    end
    n_cmp++;
    if (ill_count_o !== 8'hFF) begin
      n_fail++; $display("FAIL sat_final got %h want ff", ill_count_o);
    end
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    n_cmp++;
    if ({illegal_o, ill_count_o} !== {1'b0, 8'hFF}) begin
      n_fail++; $display("FAIL sat_pulse got %b/%h want 0/ff", illegal_o, ill_count_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_cycle(1'b1, 32'h0020A423, 32'h0000_0400, 1'b0, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (observed_bus() !== 92'd0 || {illegal_o, ill_count_o} !== 9'd0) begin
      n_fail++; $display("FAIL async_reset got %h ill=%b cnt=%0d want 0", observed_bus(), illegal_o, ill_count_o);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_valid = 1'b0; exp_fields = '0; exp_ill = 1'b0; exp_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_beq();
    test_flush();
    test_random();
    test_saturate();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
